// File: rtl/dbs.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Divide errors (zero divisor or quotient overflow) are reported on the accepting edge.
module dbs #(
  parameter int unsigned LARGURA = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [2*LARGURA-1:0]   dividendo,
  input  logic [LARGURA-1:0]     divisor,
  output logic [LARGURA-1:0]     quociente,
  output logic [LARGURA-1:0]     resto,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   erro
);

  localparam int unsigned W    = LARGURA;
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [0:0] {StRepouso, StCalcula} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [W:0]      r_q;
  logic [W-1:0]    q_q;
  logic [W-1:0]    d_q;
  logic [W-1:0]    quociente_q;
  logic [W-1:0]    resto_q;
  logic            ocupado_q;
  logic            pronto_q;
  logic            erro_q;

  logic [W:0]      r_sh;
  logic [W+1:0]    t;
  logic [W:0]      r_nxt;
  logic [W-1:0]    q_nxt;
  logic            div_err;
  logic            last;

  // One restoring step; R stays below D, so the shifted value fits in W+1 bits.
  always_comb begin
    r_sh    = {r_q[W-1:0], q_q[W-1]};
    t       = {1'b0, r_sh} - {2'b00, d_q};
    r_nxt   = t[W+1] ? r_sh : t[W:0];
    q_nxt   = {q_q[W-2:0], ~t[W+1]};
    div_err = (divisor == '0) || (dividendo[2*W-1:W] >= divisor);
    last    = (cnt_q == CntW'(W - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRepouso;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quociente_q <= '0;
      resto_q     <= '0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      case (state_q)
        StRepouso: begin
          if (start) begin
            if (div_err) begin
              quociente_q <= '1;
              resto_q     <= '0;
              erro_q      <= 1'b1;
              pronto_q    <= 1'b1;
            end else begin
              r_q       <= {1'b0, dividendo[2*W-1:W]};
              q_q       <= dividendo[W-1:0];
              d_q       <= divisor;
              cnt_q     <= '0;
              state_q   <= StCalcula;
              ocupado_q <= 1'b1;
              erro_q    <= 1'b0;
              pronto_q  <= 1'b0;
            end
          end else begin
            pronto_q <= 1'b0;
          end
        end
        StCalcula: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            quociente_q <= q_nxt;
            resto_q     <= r_nxt[W-1:0];
            pronto_q    <= 1'b1;
            erro_q      <= 1'b0;
            ocupado_q   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StRepouso;
          end
        end
        default: state_q <= StRepouso;
      endcase
    end
  end

  assign quociente = quociente_q;
  assign resto     = resto_q;
  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_dbs.sv
// Directed and randomised checks of the dbs divider at LARGURA=8.
module tb_dbs;

  localparam int unsigned W = 8;

  logic           clock;
  logic           reset_n;
  logic           start;
  logic [2*W-1:0] dividendo;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quociente;
  logic [W-1:0]   resto;
  logic           ocupado;
  logic           pronto;
  logic           erro;

  int unsigned n_check = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  // Output values the DUT must be holding between results.
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;

  dbs #(.LARGURA(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .erro      (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a division on the next rising edge and follows it to its result.
  task automatic run(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                     input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic ee, input logic repulse);
    start     = 1'b1;
    dividendo = dd;
    divisor   = dv;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (ee) begin
      chk("err_pronto", 32'(pronto), 32'd1);
      chk("err_erro", 32'(erro), 32'd1);
      chk("err_ocupado", 32'(ocupado), 32'd0);
      chk("err_quociente", 32'(quociente), 32'(eq));
      chk("err_resto", 32'(resto), 32'(er));
    end else begin
      chk("accept_ocupado", 32'(ocupado), 32'd1);
      chk("accept_pronto", 32'(pronto), 32'd0);
      chk("accept_erro", 32'(erro), 32'd0);
      dividendo = ~dd;
      divisor   = ~dv;
      for (int k = 1; k <= int'(W); k++) begin
        @(posedge clock);
        #1;
        if (repulse && k == 2) begin
          start     = 1'b1;
          dividendo = 16'd1;
          divisor   = 8'd0;
        end
        if (repulse && k == 5) start = 1'b0;
        if (k < int'(W)) begin
          chk("busy_ocupado", 32'(ocupado), 32'd1);
          chk("busy_pronto", 32'(pronto), 32'd0);
          chk("busy_hold_q", 32'(quociente), 32'(held_q));
          chk("busy_hold_r", 32'(resto), 32'(held_r));
        end
      end
      chk("done_pronto", 32'(pronto), 32'd1);
      chk("done_ocupado", 32'(ocupado), 32'd0);
      chk("done_erro", 32'(erro), 32'd0);
      chk("done_quociente", 32'(quociente), 32'(eq));
      chk("done_resto", 32'(resto), 32'(er));
    end
    held_q = eq;
    held_r = er;
  endtask

  initial begin
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [W-1:0]   eq;
    logic [W-1:0]   er;
    logic           ee;

    reset_n   = 1'b0;
    start     = 1'b0;
    dividendo = '0;
    divisor   = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_quociente", 32'(quociente), 32'd0);
    chk("rst_resto", 32'(resto), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    @(negedge clock);
    run(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk("idle_pronto_falls", 32'(pronto), 32'd0);
    chk("idle_hold_q", 32'(quociente), 32'd142);
    chk("idle_hold_r", 32'(resto), 32'd6);

    @(negedge clock);
    run(16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0);
    @(negedge clock);
    run(16'd0, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clock);
    run(16'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);

    @(negedge clock);
    run(16'd1234, 8'd0, 8'd255, 8'd0, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    chk("err_pronto_falls", 32'(pronto), 32'd0);
    chk("err_erro_held", 32'(erro), 32'd1);
    chk("err_ocupado_low", 32'(ocupado), 32'd0);
    @(negedge clock);
    run(16'h1234, 8'h12, 8'd255, 8'd0, 1'b1, 1'b0);
    @(negedge clock);
    run(16'h1234, 8'h13, 8'd245, 8'd5, 1'b0, 1'b0);

    // start re-asserted mid-computation must be ignored
    @(negedge clock);
    run(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b1);

    // back-to-back: start held high in the pronto cycle
    @(negedge clock);
    run(16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0);
    run(16'h1234, 8'h13, 8'd245, 8'd5, 1'b0, 1'b0);
    run(16'd1234, 8'd0, 8'd255, 8'd0, 1'b1, 1'b0);
    run(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0);

    // asynchronous reset during iteration 4
    @(negedge clock);
    start     = 1'b1;
    dividendo = 16'd4660;
    divisor   = 8'd19;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_quociente", 32'(quociente), 32'd0);
    chk("arst_resto", 32'(resto), 32'd0);
    chk("arst_ocupado", 32'(ocupado), 32'd0);
    chk("arst_pronto", 32'(pronto), 32'd0);
    chk("arst_erro", 32'(erro), 32'd0);
    held_q = '0;
    held_r = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      chk("arst_no_pronto", 32'(pronto), 32'd0);
      chk("arst_no_ocupado", 32'(ocupado), 32'd0);
    end
    @(negedge clock);
    run(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0);

    // random operands against an integer reference
    for (int i = 0; i < 1000; i++) begin
      dv = 8'($urandom_range(0, 255));
      dd = 16'($urandom_range(0, 65535));
      if (dv != 8'd0 && $urandom_range(0, 3) != 0) dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
      ee = (dv == 8'd0) || (dd[15:8] >= dv);
      if (ee) begin
        eq = 8'hff;
        er = 8'd0;
      end else begin
        eq = 8'(int'(dd) / int'(dv));
        er = 8'(int'(dd) % int'(dv));
      end
      @(negedge clock);
      run(dd, dv, eq, er, ee, 1'b0);
      if (!ee) begin
        chk("inv_product", int'(quociente) * int'(dv) + int'(resto), 32'(dd));
        chk("inv_resto_lt", 32'(resto < dv), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
